// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared CPU bus constants and timer types
//
// Purpose: register offsets and IO base addresses for the 0xFFxx IO page,
// the timer reload state type, and the TAC clock-select helper.
// Ports: none (package).
package gb_bus_pkg;

  // IO page base addresses
  localparam logic [15:0] IO_BASE_ADDR    = 16'hFF00;
  localparam logic [15:0] TIMER_BASE_ADDR = 16'hFF04;
  localparam logic [15:0] IF_ADDR         = 16'hFF0F;

  // Timer register offsets from the timer base
  localparam logic [1:0] DIV_OFS  = 2'd0;
  localparam logic [1:0] TIMA_OFS = 2'd1;
  localparam logic [1:0] TMA_OFS  = 2'd2;
  localparam logic [1:0] TAC_OFS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    RELOAD = 2'd2
  } timer_state_t;

  // div_cnt bit that clocks TIMA for a given TAC[1:0] setting
  function automatic logic [3:0] tac_bit(input logic [1:0] clk_sel);
    logic [3:0] b;
    case (clk_sel)
      2'b00:   b = 4'd9;
      2'b01:   b = 4'd3;
      2'b10:   b = 4'd5;
      default: b = 4'd7;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gb_timer_edge.sv
// rtl/gb_timer_edge.sv - divider counter and TIMA tick edge detector
//
// Purpose: free-running 16-bit divider, TAC bit-select mux and the
// falling-edge detector that produces the TIMA increment tick.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   div_clr_i   DIV write this cycle (clears the divider)
//   tac_next_i  TAC value after this edge (enable + clock select)
//   div_cnt_o   current divider value
//   tick_o      TIMA increment request for this edge
module gb_timer_edge
  import gb_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        div_clr_i,
  input  logic [2:0]  tac_next_i,
  output logic [15:0] div_cnt_o,
  output logic        tick_o
);

  logic [15:0] div_cnt_q, div_cnt_d;
  logic        prev_sig_q;
  logic        sig_next;

  // A DIV write overrides the normal increment
  assign div_cnt_d = div_clr_i ? 16'h0000 : div_cnt_q + 16'd1;

  // Timer signal as it will be after this edge; comparing it with the
  // registered current value makes DIV/TAC writes able to produce a tick.
  assign sig_next = tac_next_i[2] & div_cnt_d[tac_bit(tac_next_i[1:0])];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= 16'h0000;
      prev_sig_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      prev_sig_q <= sig_next;
    end
  end

  assign tick_o    = prev_sig_q & ~sig_next;
  assign div_cnt_o = div_cnt_q;

endmodule

// File: rtl/gb_timer.sv
// rtl/gb_timer.sv - memory-mapped DIV/TIMA/TMA/TAC timer
//
// Purpose: timer register file, TIMA overflow reload sequencer and CPU bus
// decode for the four timer registers at BASE_ADDR..BASE_ADDR+3.
// Ports:
//   clk        system clock (one tick per T-cycle)
//   rst_n      asynchronous active-low reset
//   adr        CPU address
//   data_in    CPU write data
//   wr_en      CPU write strobe
//   data_out   read data, combinational from adr (0xFF when not selected)
//   sel        address decode hit
//   irq_timer  one-cycle timer interrupt request
module gb_timer
  import gb_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = TIMER_BASE_ADDR,
  parameter int          RELOAD_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] adr,
  input  logic [7:0]  data_in,
  input  logic        wr_en,
  output logic [7:0]  data_out,
  output logic        sel,
  output logic        irq_timer
);

  localparam int CNT_W = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RELOAD_DELAY - 1);

  timer_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tima_q, tima_d;
  logic [7:0]       tma_q, tma_d;
  logic [2:0]       tac_q, tac_d;

  logic [1:0]  ofs;
  logic        wr_hit, div_wr, tima_wr, tma_wr, tac_wr;
  logic [15:0] div_cnt;
  logic        tick;

  // Bus decode
  assign sel     = (adr[15:2] == BASE_ADDR[15:2]);
  assign ofs     = adr[1:0];
  assign wr_hit  = wr_en & sel;
  assign div_wr  = wr_hit & (ofs == DIV_OFS);
  assign tima_wr = wr_hit & (ofs == TIMA_OFS);
  assign tma_wr  = wr_hit & (ofs == TMA_OFS);
  assign tac_wr  = wr_hit & (ofs == TAC_OFS);

  assign tma_d = tma_wr ? data_in : tma_q;
  assign tac_d = tac_wr ? data_in[2:0] : tac_q;

  gb_timer_edge u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_clr_i  (div_wr),
    .tac_next_i (tac_d),
    .div_cnt_o  (div_cnt),
    .tick_o     (tick)
  );

  // Reload sequencer and TIMA next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tima_d  = tima_q;
    case (state_q)
      IDLE: begin
        if (tima_wr) begin
          tima_d = data_in;
        end else if (tick) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = DELAY;
            cnt_d   = CNT_LOAD;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      DELAY: begin
        // Ticks are dropped here; a TIMA write aborts the pending reload
        if (tima_wr) begin
          tima_d  = data_in;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          tima_d  = tma_d;
          state_d = RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELOAD: begin
        // TIMA tracks TMA for this cycle, so a TMA write lands in TIMA too;
        // CPU writes to TIMA are lost.
        tima_d  = tma_d;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
    end
  end

  assign irq_timer = (state_q == RELOAD);

  // Read mux
  always_comb begin
    data_out = 8'hFF;
    if (sel) begin
      case (ofs)
        DIV_OFS:  data_out = div_cnt[15:8];
        TIMA_OFS: data_out = tima_q;
        TMA_OFS:  data_out = tma_q;
        default:  data_out = {5'b11111, tac_q};
      endcase
    end
  end

endmodule

// File: tb/tb_gb_timer.sv
// tb/tb_gb_timer.sv - self-checking bench for gb_timer
module tb_gb_timer;

  logic        clk;
  logic        rst_n;
  logic [15:0] adr;
  logic [7:0]  data_in;
  logic        wr_en;
  logic [7:0]  data_out;
  logic        sel;
  logic        irq_timer;

  int n_cmp = 0;
  int n_bad = 0;

  gb_timer #(
    .BASE_ADDR    (16'hFF04),
    .RELOAD_DELAY (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adr       (adr),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .data_out  (data_out),
    .sel       (sel),
    .irq_timer (irq_timer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] adr;
    logic [7:0]  din;
    logic [15:0] chk_adr;
    logic [7:0]  exp_dout;
    logic        exp_sel;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One bus write, consuming exactly one rising edge; returns at edge+1
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    adr     = a;
    data_in = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Clear DIV, load TIMA=FF and wait for the overflow edge (TAC=101 active).
  // Returns at overflow edge+1 with the number of edges waited.
  task automatic ovf(output int n);
    wr(16'hFF04, 8'h00);
    wr(16'hFF05, 8'hFF);
    adr = 16'hFF05;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (data_out == 8'h00) begin
        n = k;
        break;
      end
    end
    if (n == 0) n = 99;
  endtask

  initial begin
    int n;
    logic irq_seen;

    vecs[0]  = '{1'b0, 16'hFF07, 8'h00, 16'hFF07, 8'hF8, 1'b1};
    vecs[1]  = '{1'b0, 16'h1234, 8'h00, 16'h1234, 8'hFF, 1'b0};
    vecs[2]  = '{1'b0, 16'hFF03, 8'h00, 16'hFF03, 8'hFF, 1'b0};
    vecs[3]  = '{1'b0, 16'hFF08, 8'h00, 16'hFF08, 8'hFF, 1'b0};
    vecs[4]  = '{1'b0, 16'hFF05, 8'h00, 16'hFF05, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 16'hFF06, 8'h00, 16'hFF06, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 16'hFF06, 8'hA5, 16'hFF06, 8'hA5, 1'b1};
    vecs[7]  = '{1'b1, 16'hFF07, 8'h03, 16'hFF07, 8'hFB, 1'b1};
    vecs[8]  = '{1'b1, 16'hFF05, 8'h7C, 16'hFF05, 8'h7C, 1'b1};
    vecs[9]  = '{1'b1, 16'h1234, 8'h00, 16'hFF06, 8'hA5, 1'b1};
    vecs[10] = '{1'b1, 16'hFF08, 8'h11, 16'hFF05, 8'h7C, 1'b1};
    vecs[11] = '{1'b1, 16'hFF07, 8'hF8, 16'hFF07, 8'hF8, 1'b1};

    clk     = 1'b0;
    rst_n   = 1'b0;
    adr     = 16'hFF07;
    data_in = 8'h00;
    wr_en   = 1'b0;

    // Reset state visible through the decode while held in reset
    #12;
    check("rst_tac_dout", {8'h00, data_out}, 16'h00F8);
    check("rst_tac_sel", {15'h0, sel}, 16'h0001);
    check("rst_irq", {15'h0, irq_timer}, 16'h0000);
    adr = 16'hFF04;
    #1;
    check("rst_div", {8'h00, data_out}, 16'h0000);

    // DIV after 512 counting edges
    rst_n = 1'b1;
    repeat (511) @(posedge clk);
    #1;
    check("div_511", {8'h00, data_out}, 16'h0001);
    @(posedge clk);
    #1;
    check("div_512", {8'h00, data_out}, 16'h0002);

    // Register/decode table, timer disabled
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].wr) wr(vecs[i].adr, vecs[i].din);
      adr = vecs[i].chk_adr;
      #1;
      check($sformatf("vec%0d_dout", i), {8'h00, data_out}, {8'h00, vecs[i].exp_dout});
      check($sformatf("vec%0d_sel", i), {15'h0, sel}, {15'h0, vecs[i].exp_sel});
    end

    // 160 clocks with bit3 selected: 10 increments
    wr(16'hFF04, 8'h00);
    wr(16'hFF07, 8'h05);
    wr(16'hFF05, 8'h00);
    adr = 16'hFF05;
    repeat (160) @(posedge clk);
    #1;
    check("tima_160clk", {8'h00, data_out}, 16'h000A);

    // Overflow, 4-cycle hold, reload and one-cycle irq
    wr(16'hFF06, 8'hF0);
    ovf(n);
    check("ovf_edge_count", n[15:0], 16'd15);
    check("ovf_e0_irq", {15'h0, irq_timer}, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("ovf_e%0d_tima", k), {8'h00, data_out}, 16'h0000);
      check($sformatf("ovf_e%0d_irq", k), {15'h0, irq_timer}, 16'h0000);
    end
    @(posedge clk);
    #1;
    check("ovf_e4_tima", {8'h00, data_out}, 16'h00F0);
    check("ovf_e4_irq", {15'h0, irq_timer}, 16'h0001);
    @(posedge clk);
    #1;
    check("ovf_e5_tima", {8'h00, data_out}, 16'h00F0);
    check("ovf_e5_irq", {15'h0, irq_timer}, 16'h0000);

    // TMA write during the reload cycle lands in TIMA
    ovf(n);
    check("rl_edge_count", n[15:0], 16'd15);
    repeat (4) @(posedge clk);
    #1;
    check("rl_e4_irq", {15'h0, irq_timer}, 16'h0001);
    wr(16'hFF06, 8'h77);
    adr = 16'hFF05;
    #1;
    check("rl_tma_wr_tima", {8'h00, data_out}, 16'h0077);
    check("rl_e5_irq", {15'h0, irq_timer}, 16'h0000);

    // TIMA write two clocks after overflow cancels reload and irq
    ovf(n);
    check("cx_edge_count", n[15:0], 16'd15);
    @(posedge clk);
    #1;
    wr(16'hFF05, 8'h33);
    adr = 16'hFF05;
    irq_seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      irq_seen = irq_seen | irq_timer;
    end
    check("cx_tima", {8'h00, data_out}, 16'h0033);
    check("cx_no_irq", {15'h0, irq_seen}, 16'h0000);

    // DIV write while bit3 is high produces exactly one increment
    wr(16'hFF04, 8'h00);
    wr(16'hFF05, 8'h40);
    repeat (7) @(posedge clk);
    adr = 16'hFF05;
    #1;
    check("sp_before", {8'h00, data_out}, 16'h0040);
    wr(16'hFF04, 8'h5A);
    adr = 16'hFF05;
    #1;
    check("sp_tima", {8'h00, data_out}, 16'h0041);
    adr = 16'hFF04;
    #1;
    check("sp_div", {8'h00, data_out}, 16'h0000);
    adr = 16'hFF05;
    repeat (4) @(posedge clk);
    #1;
    check("sp_tima_hold", {8'h00, data_out}, 16'h0041);

    // Asynchronous reset during DELAY
    wr(16'hFF06, 8'hF0);
    ovf(n);
    check("ar_edge_count", n[15:0], 16'd15);
    @(posedge clk);
    #1;
    adr = 16'hFF06;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_tma", {8'h00, data_out}, 16'h0000);
    check("ar_irq", {15'h0, irq_timer}, 16'h0000);
    adr = 16'hFF07;
    #1;
    check("ar_tac", {8'h00, data_out}, 16'h00F8);
    adr = 16'hFF05;
    irq_seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      irq_seen = irq_seen | irq_timer;
    end
    #2;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      irq_seen = irq_seen | irq_timer;
    end
    check("ar_no_irq", {15'h0, irq_seen}, 16'h0000);
    check("ar_tima", {8'h00, data_out}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gb_timer.md
Name: gb_timer

Overview:
- Memory-mapped DIV/TIMA/TMA/TAC timer that responds on the CPU data bus at 0xFF04-0xFF07.
- Sits beside iram on the cpu address_out/data_out/cpu_wr bus. Returns read data on data_out and a decode hit on sel so the top-level bus mux can choose between it and iram.
- Raises a one-cycle timer interrupt request on TIMA overflow after the reload delay.

Parameters:
BASE_ADDR, 16'hFF04, address of DIV; TIMA/TMA/TAC at +1/+2/+3
RELOAD_DELAY, 4, clk cycles TIMA holds 0x00 after overflow before TMA reload

Ports:
clk  input  1  system clock, one tick = one T-cycle
rst_n  input  1  asynchronous active-low reset
adr  input  16  CPU address (cpu address_out)
data_in  input  8  CPU write data (cpu data_out)
wr_en  input  1  CPU write strobe (cpu_wr), active high
data_out  output  8  read data, combinational from adr
sel  output  1  high when adr is in BASE_ADDR..BASE_ADDR+3
irq_timer  output  1  one-cycle interrupt request pulse

Behaviour:
- Reset (async, rst_n=0): div_cnt=16'h0000, TIMA=8'h00, TMA=8'h00, TAC=3'b000, reload state IDLE, delay counter 0, irq_timer=0, prev_sig=0.
  - While in reset, data_out and sel follow the combinational decode of the reset register values.
- Reset asserted mid-operation aborts any pending reload and any irq.
- div_cnt: 16-bit counter, +1 every clk, wraps 0xFFFF->0x0000. DIV read value = div_cnt[15:8].
- Register decode, combinational:
  - sel=1 iff adr[15:2]==BASE_ADDR[15:2].
  - data_out: DIV -> div_cnt[15:8]; TIMA -> TIMA; TMA -> TMA; TAC -> {5'b11111, TAC}.
  - When sel=0, data_out=8'hFF.
- Writes take effect on the rising clk edge when wr_en & sel:
  - DIV: any value clears div_cnt to 0.
  - TIMA: loads data_in.
  - TMA: loads data_in.
  - TAC: loads data_in[2:0].
- Timer signal: sig = TAC[2] & div_cnt[bit], where bit is 9/3/5/7 for TAC[1:0] = 00/01/10/11. prev_sig is registered each cycle.
  - TIMA increments when prev_sig=1 and sig_next=0 (falling edge), where sig_next is computed from the post-edge div_cnt and TAC.
  - A DIV write, or a TAC write that disables the timer or changes the selected bit, can therefore cause a spurious increment. This is required behaviour.
- Overflow: an increment from 0xFF sets TIMA=0x00 and enters DELAY with count=RELOAD_DELAY-1.
- DELAY state:
  - Each cycle, decrement count. At count=0, transition to RELOAD.
  - A TIMA write during DELAY loads data_in, returns to IDLE, and cancels both the reload and the irq.
  - Increments are suppressed during DELAY.
- RELOAD (one cycle):
  - TIMA<=TMA; irq_timer=1 for exactly this cycle; then IDLE.
  - A TMA write in the RELOAD cycle: TIMA gets the new data_in.
  - A TIMA write in the RELOAD cycle is ignored.
- Simultaneous events:
  - A CPU write to TIMA beats an increment in the same cycle.
  - A DIV write beats the div_cnt increment (result 0).
- Total latency: overflow edge to irq_timer high = RELOAD_DELAY cycles, from the edge at which TIMA becomes 0x00 to the edge at which irq_timer rises.

Decomposition:
- Shared package gb_bus_pkg:
  - Register offset constants: DIV_OFS=2'd0, TIMA_OFS=2'd1, TMA_OFS=2'd2, TAC_OFS=2'd3.
  - IO base addresses.
  - typedef enum {IDLE, DELAY, RELOAD} timer_state_t.
- One natural sub-module: gb_timer_edge. It holds the div_cnt counter, the TAC bit-select mux and prev_sig, and outputs tick (the falling-edge pulse).
- Register file, reload FSM and bus decode stay in gb_timer.

Test Plan:
- Reset, then read 0xFF07 -> data_out=8'hF8, sel=1. Read 0x1234 -> data_out=8'hFF, sel=0. Read 0xFF04 after 512 clks -> 8'h02.
- Write TAC=3'b101 (bit3, enabled), TIMA=8'h00, then run 160 clks -> TIMA=8'h0A (one increment per 16 clks).
- TMA=8'hF0, TIMA=8'hFF, TAC=3'b101 -> at the next bit3 falling edge TIMA=8'h00 and holds 4 clks. On the 4th clk, irq_timer=1 for one cycle and TIMA=8'hF0.
- Same setup, but write TIMA=8'h33 two clks after overflow -> TIMA=8'h33, irq_timer never asserts, no reload.
- TAC=3'b101, run until div_cnt[3]=1, then write DIV -> div_cnt=0 and TIMA increments by exactly 1 (spurious edge).
- Assert rst_n=0 during DELAY -> irq_timer stays 0 and all registers return to reset values immediately, without waiting for a clk edge.
